// File: rtl/lpddr5_req_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lpddr5_req_ctrl_pkg
// Shared definitions for the LPDDR5 request controller, its request queue and
// the memory model used alongside it.
//   - state_t          : controller state encoding
//   - DEF_ADDR_WIDTH   : default memory word address width
//   - DEF_DATA_WIDTH   : default memory word width
//   - DEF_FIFO_DEPTH   : default request queue depth
//   - DEF_IDLE_TIMEOUT : default idle cycles before entering sleep
// ----------------------------------------------------------------------------
package lpddr5_req_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_IDLE_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_SLEEP   = 3'd4,
    ST_WAKE    = 3'd5
  } state_t;

endpackage

// File: rtl/lpddr5_req_ctrl_if.sv
// ----------------------------------------------------------------------------
// lpddr5_req_ctrl_if
// Bundles the host request/response handshake, the memory command bus and the
// status flags of the request controller.
//   master : host + memory side (drives requests, rsp_ready, mem_rd_data)
//   slave  : controller side (drives req_ready, responses, mem commands, flags)
// ----------------------------------------------------------------------------
interface lpddr5_req_ctrl_if
  import lpddr5_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  // host request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  // host response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  // memory command bus
  logic                  mem_clk_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  // status
  logic                  busy;
  logic                  sleeping;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_clk_en, mem_addr, mem_wr_data,
           mem_wr_en, mem_rd_en, busy, sleeping
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, mem_clk_en, mem_addr, mem_wr_data,
           mem_wr_en, mem_rd_en, busy, sleeping
  );

endinterface

// File: rtl/lpddr5_req_fifo.sv
// ----------------------------------------------------------------------------
// lpddr5_req_fifo
// Synchronous in-order FIFO holding queued memory requests.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (empties the queue)
//   i_push  : write i_wdata when not full
//   i_wdata : entry to enqueue
//   i_pop   : drop head entry when not empty
//   o_rdata : current head entry (valid when !o_empty)
//   o_full  : DEPTH entries stored
//   o_empty : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module lpddr5_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Full is judged before any same-cycle pop so req_ready never depends on it.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage is not reset: only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Head is read combinationally so the controller can decide in one cycle.
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lpddr5_req_ctrl.sv
// ----------------------------------------------------------------------------
// lpddr5_req_ctrl
// Queues host read/write requests and sequences them onto a simple memory
// command bus, with an idle-timeout sleep mode that gates the memory clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lpddr5_req_ctrl_if.slave
//           req_*  host requests (valid/ready), rsp_* read responses
//           mem_*  registered memory command bus, mem_rd_data returned data
//           busy / sleeping status flags
// Writes drive mem_wr_en for two cycles; reads drive mem_rd_en for one cycle
// and capture mem_rd_data one cycle later. Only one response is outstanding.
// ----------------------------------------------------------------------------
module lpddr5_req_ctrl
  import lpddr5_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  lpddr5_req_ctrl_if.slave  bus
);

  localparam int QW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

  // queue
  logic [QW-1:0]         w_push_data;
  logic [QW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;

  // state and registered outputs
  state_t                r_state, w_state_next;
  logic                  r_wr_second, w_wr_second_next;
  logic [CW-1:0]         r_idle_cnt, w_idle_cnt_next;
  logic                  r_mem_clk_en, w_mem_clk_en_next;
  logic                  r_mem_wr_en, w_mem_wr_en_next;
  logic                  r_mem_rd_en, w_mem_rd_en_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0] r_mem_wr_data, w_mem_wr_data_next;
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_next;
  logic                  w_rsp_slot_free;

  assign w_push_data  = {bus.req_we, bus.req_addr, bus.req_wdata};
  assign w_head_we    = w_head[QW-1];
  assign w_head_addr  = w_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign w_head_wdata = w_head[DATA_WIDTH-1:0];

  lpddr5_req_fifo #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.req_valid),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A read may start when no response is pending or the pending one is being
  // accepted this very cycle (it clears before the new one lands).
  assign w_rsp_slot_free = !r_rsp_valid || bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_second   <= 1'b0;
      r_idle_cnt    <= '0;
      r_mem_clk_en  <= 1'b1;
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wr_second   <= w_wr_second_next;
      r_idle_cnt    <= w_idle_cnt_next;
      r_mem_clk_en  <= w_mem_clk_en_next;
      r_mem_wr_en   <= w_mem_wr_en_next;
      r_mem_rd_en   <= w_mem_rd_en_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wr_data <= w_mem_wr_data_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_rdata   <= w_rsp_rdata_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pop              = 1'b0;
    w_wr_second_next   = 1'b0;
    w_idle_cnt_next    = '0;
    w_mem_wr_en_next   = 1'b0;
    w_mem_rd_en_next   = 1'b0;
    w_mem_addr_next    = r_mem_addr;
    w_mem_wr_data_next = r_mem_wr_data;
    w_rsp_valid_next   = r_rsp_valid && !bus.rsp_ready;
    w_rsp_rdata_next   = r_rsp_rdata;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_head_we) begin
            w_pop              = 1'b1;
            w_state_next       = ST_WRITE;
            w_mem_wr_en_next   = 1'b1;
            w_mem_addr_next    = w_head_addr;
            w_mem_wr_data_next = w_head_wdata;
          end else if (w_rsp_slot_free) begin
            w_pop            = 1'b1;
            w_state_next     = ST_READ;
            w_mem_rd_en_next = 1'b1;
            w_mem_addr_next  = w_head_addr;
          end
        end else if (!r_rsp_valid) begin
          // Only a fully quiet controller counts toward sleep.
          if (r_idle_cnt == IDLE_LAST) begin
            w_state_next = ST_SLEEP;
          end else begin
            w_idle_cnt_next = r_idle_cnt + CW'(1);
          end
        end
      end
      ST_WRITE: begin
        // First WRITE cycle keeps the strobe up for a second beat.
        if (!r_wr_second) begin
          w_mem_wr_en_next = 1'b1;
          w_wr_second_next = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        w_state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Memory returns data one cycle after the read strobe.
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = bus.mem_rd_data;
        w_state_next     = ST_IDLE;
      end
      ST_SLEEP: begin
        if (!w_empty) begin
          w_state_next = ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_mem_clk_en_next = (w_state_next != ST_SLEEP);
  end

  assign bus.req_ready   = !w_full;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.mem_clk_en  = r_mem_clk_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.busy        = ((r_state != ST_IDLE) && (r_state != ST_SLEEP)) || !w_empty;
  assign bus.sleeping    = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_lpddr5_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lpddr5_req_ctrl
// Directed bench for lpddr5_req_ctrl: reset values, two-beat write, read with
// held response, queue full back-pressure and ordering, reset during a write,
// idle sleep and wake-up read. Includes a one-cycle-latency memory model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lpddr5_req_ctrl;
  import lpddr5_req_ctrl_pkg::*;

  localparam logic [63:0] D1 = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D5 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_0000_0050;
  localparam logic [63:0] D6 = 64'hCAFE_F00D_0000_0060;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  lpddr5_req_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus ();

  lpddr5_req_ctrl #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (64),
    .FIFO_DEPTH   (4),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // memory model: write on strobe, read data one cycle after mem_rd_en
  logic [63:0] mem_arr [0:255];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_arr[bus.mem_addr[7:0]];
  end

  // command / response logger, sampled away from the active edge
  logic [63:0] ops_q [$];
  logic [63:0] rsp_q [$];
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_wr_en && !prev_wr) ops_q.push_back({47'd0, 1'b1, bus.mem_addr});
    if (bus.mem_rd_en && !prev_rd) ops_q.push_back({48'd0, bus.mem_addr});
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_q.push_back(bus.rsp_rdata);
      $display("rsp   data=%h", bus.rsp_rdata);
    end
    prev_wr = bus.mem_wr_en;
    prev_rd = bus.mem_rd_en;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [15:0] addr, input logic [63:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    $display("req   we=%0d addr=%h data=%h ready=%0d", we, addr, data, bus.req_ready);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({pfx, "_rsp_rdata"}, bus.rsp_rdata, 64'd0);
    check({pfx, "_clk_en"},    64'(bus.mem_clk_en), 64'd1);
    check({pfx, "_addr"},      64'(bus.mem_addr), 64'd0);
    check({pfx, "_wr_data"},   bus.mem_wr_data, 64'd0);
    check({pfx, "_wr_en"},     64'(bus.mem_wr_en), 64'd0);
    check({pfx, "_rd_en"},     64'(bus.mem_rd_en), 64'd0);
    check({pfx, "_busy"},      64'(bus.busy), 64'd0);
    check({pfx, "_sleeping"},  64'(bus.sleeping), 64'd0);
  endtask

  // stalled-queue stimulus and expected command order
  logic        q_we   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] q_addr [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h0020, 16'h0040};
  logic [63:0] q_data [5] = '{64'd0, D2, D3, 64'd0, D5};
  logic [63:0] exp_ops [7] = '{64'h1_0010, 64'h0_0010, 64'h0_0010, 64'h1_0020,
                               64'h1_0030, 64'h0_0020, 64'h1_0040};
  logic [63:0] exp_rsp [3] = '{D1, D1, D2};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    int   n_ops_snap;
    int   n_rsp_snap;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    check_reset_values("rst");
    rst_n = 1'b1;

    // two-beat write
    drive_req(1'b1, 16'h0010, D1);
    step();
    bus.req_valid = 1'b0;
    step();
    check("wr_beat1_en",   64'(bus.mem_wr_en), 64'd1);
    check("wr_beat1_addr", 64'(bus.mem_addr), 64'h0010);
    check("wr_beat1_data", bus.mem_wr_data, D1);
    step();
    check("wr_beat2_en",   64'(bus.mem_wr_en), 64'd1);
    check("wr_beat2_addr", 64'(bus.mem_addr), 64'h0010);
    check("wr_beat2_data", bus.mem_wr_data, D1);
    step();
    check("wr_end_en",   64'(bus.mem_wr_en), 64'd0);
    check("wr_end_busy", 64'(bus.busy), 64'd0);

    // read with response held by rsp_ready=0
    drive_req(1'b0, 16'h0010, 64'd0);
    step();
    bus.req_valid = 1'b0;
    step();
    check("rd_en",   64'(bus.mem_rd_en), 64'd1);
    check("rd_addr", 64'(bus.mem_addr), 64'h0010);
    step();
    check("rd_en_off",   64'(bus.mem_rd_en), 64'd0);
    check("rd_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_rdata", bus.rsp_rdata, D1);

    // five back-to-back requests while the queue head is stalled
    for (int i = 0; i < 5; i++) begin
      drive_req(q_we[i], q_addr[i], q_data[i]);
      step();
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", bus.rsp_rdata, D1);
      check("stall_rd_en", 64'(bus.mem_rd_en), 64'd0);
      check("fill_ready", 64'(bus.req_ready), (i < 3) ? 64'd1 : 64'd0);
    end
    check("no_second_read", 64'(ops_q.size()), 64'd2);
    check("stall_busy", 64'(bus.busy), 64'd1);

    bus.rsp_ready = 1'b1;
    step();
    check("ready_after_pop", 64'(bus.req_ready), 64'd1);
    check("rsp_cleared",     64'(bus.rsp_valid), 64'd0);
    check("rd2_en",          64'(bus.mem_rd_en), 64'd1);
    step();
    bus.req_valid = 1'b0;

    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      done = !bus.busy && !bus.rsp_valid;
    end
    check("drain_done", 64'(done), 64'd1);
    check("ops_count", 64'(ops_q.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      check("op_order", (i < ops_q.size()) ? ops_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_ops[i]);
    check("rsp_count", 64'(rsp_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check("rsp_order", (i < rsp_q.size()) ? rsp_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_rsp[i]);
    check("mem_0040", mem_arr[8'h40], D5);

    // reset during the second write beat with two requests queued
    drive_req(1'b1, 16'h0050, DX);
    step();
    drive_req(1'b0, 16'h0050, 64'd0);
    step();
    check("rw_beat1", 64'(bus.mem_wr_en), 64'd1);
    drive_req(1'b1, 16'h0060, D6);
    step();
    bus.req_valid = 1'b0;
    check("rw_beat2", 64'(bus.mem_wr_en), 64'd1);
    check("rw_busy",  64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    n_ops_snap = ops_q.size();
    n_rsp_snap = rsp_q.size();
    check("rst_ops_snap", 64'(n_ops_snap), 64'd8);
    repeat (2) step();
    rst_n = 1'b1;

    // quiet for the idle timeout, then sleep
    repeat (15) step();
    check("pre_sleep",     64'(bus.sleeping), 64'd0);
    check("pre_sleep_clk", 64'(bus.mem_clk_en), 64'd1);
    step();
    check("sleeping",   64'(bus.sleeping), 64'd1);
    check("sleep_clk",  64'(bus.mem_clk_en), 64'd0);
    check("sleep_busy", 64'(bus.busy), 64'd0);
    check("post_rst_no_ops", 64'(ops_q.size()), 64'(n_ops_snap));
    check("post_rst_no_rsp", 64'(rsp_q.size()), 64'(n_rsp_snap));

    // wake-up read
    drive_req(1'b0, 16'h0010, 64'd0);
    step();
    bus.req_valid = 1'b0;
    check("sleep_enqueue", 64'(bus.sleeping), 64'd1);
    check("sleep_q_busy",  64'(bus.busy), 64'd1);
    step();
    check("wake_sleeping", 64'(bus.sleeping), 64'd0);
    check("wake_clk",      64'(bus.mem_clk_en), 64'd1);
    check("wake_rd_en",    64'(bus.mem_rd_en), 64'd0);
    check("wake_wr_en",    64'(bus.mem_wr_en), 64'd0);
    step();
    check("wake_idle_rd_en", 64'(bus.mem_rd_en), 64'd0);
    step();
    check("wake_read_en", 64'(bus.mem_rd_en), 64'd1);
    check("wake_read_clk", 64'(bus.mem_clk_en), 64'd1);
    step();
    step();
    check("wake_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("wake_rsp_rdata", bus.rsp_rdata, D1);
    step();
    check("wake_rsp_clear", 64'(bus.rsp_valid), 64'd0);
    check("final_rsp_count", 64'(rsp_q.size()), 64'd4);
    check("final_ops_count", 64'(ops_q.size()), 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lpddr5_req_ctrl.md
LPDDR5_REQ_CTRL -- requirements
Module: lpddr5_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory word width (even).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 16, idle cycles before sleep (>=1).
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  req_valid  in  1  host request valid.
  req_ready  out  1  queue can accept.
  req_we  in  1  1=write, 0=read.
  req_addr  in  ADDR_WIDTH  request address.
  req_wdata  in  DATA_WIDTH  write data.
  rsp_valid  out  1  read data valid.
  rsp_ready  in  1  host accepts read data.
  rsp_rdata  out  DATA_WIDTH  read data.
  mem_clk_en  out  1  memory clock enable.
  mem_addr  out  ADDR_WIDTH  memory address.
  mem_wr_data  out  DATA_WIDTH  memory write data.
  mem_wr_en  out  1  memory write enable.
  mem_rd_en  out  1  memory read enable.
  mem_rd_data  in  DATA_WIDTH  memory read data.
  busy  out  1  state not IDLE/SLEEP or queue non-empty.
  sleeping  out  1  state is SLEEP.

Function
REQ-006 SHALL accept a request when req_valid && req_ready; req_ready = queue not full, independent of same-cycle pop.
REQ-007 SHALL store {we, addr, wdata} in a FIFO_DEPTH FIFO, in-order; pointers wrap modulo FIFO_DEPTH; simultaneous push and pop keep count unchanged.
REQ-008 SHALL implement states IDLE, WRITE, READ, RD_WAIT, SLEEP, WAKE.
REQ-009 IDLE: if queue non-empty and head is write -> pop, WRITE; head is read and response slot free (rsp_valid=0, or rsp_ready=1 this cycle) -> pop, READ; otherwise stay.
REQ-010 All mem_* outputs SHALL be registered; the command appears the cycle after the pop.
REQ-011 WRITE: mem_wr_en=1 for exactly 2 cycles with mem_addr/mem_wr_data held constant, then mem_wr_en=0, -> IDLE.
REQ-012 READ: mem_rd_en=1 for exactly 1 cycle (cycle C), -> RD_WAIT; RD_WAIT captures mem_rd_data at end of C+1 into rsp_rdata; rsp_valid=1 from C+2, -> IDLE.
REQ-013 rsp_valid/rsp_rdata SHALL hold until rsp_ready; rsp_valid clears the cycle after handshake; at most one response outstanding.
REQ-014 Idle counter SHALL count consecutive IDLE cycles with empty queue and rsp_valid=0; it resets to 0 on any other condition; on reaching IDLE_TIMEOUT -> SLEEP.
REQ-015 SLEEP: mem_clk_en=0, mem_rd_en=mem_wr_en=0; requests still enqueue; on queue non-empty -> WAKE.
REQ-016 WAKE: mem_clk_en=1 for one cycle with no command, -> IDLE.
REQ-017 mem_clk_en SHALL be 1 in all states except SLEEP, registered.
REQ-018 mem_addr/mem_wr_data SHALL hold last values when no command is active.

Reset
REQ-019 On rst_n=0 (asynchronous, any state): state=IDLE, queue emptied, idle counter=0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, mem_clk_en=1, mem_addr=0, mem_wr_data=0, mem_wr_en=0, mem_rd_en=0, busy=0, sleeping=0.
REQ-020 Reset mid-WRITE/READ SHALL abort the command; queued and in-flight requests are discarded, no response is produced.

Structure
REQ-021 A shared package SHALL hold the state enumeration and the default ADDR_WIDTH/DATA_WIDTH constants, shared with the memory model.
REQ-022 The request queue SHALL be one sub-module, lpddr5_req_fifo (synchronous FIFO, async active-low reset, full/empty flags).

Verification
REQ-023 Write addr 0x0010 data 0xA5A5_0000_FFFF_1234 -> mem_wr_en high 2 cycles, mem_addr=0x0010 and data stable both cycles.
REQ-024 Write then read addr 0x0010 -> rsp_valid two cycles after mem_rd_en, rsp_rdata = memory model output; with rsp_ready=0 it is held 5 cycles and no second read issues.
REQ-025 Push 5 requests back-to-back with FIFO_DEPTH=4 while engine is stalled -> req_ready=0 after the 4th; the 5th is accepted only after a pop; order is preserved.
REQ-026 No traffic for 16 cycles -> sleeping=1, mem_clk_en=0; a read is then issued -> one WAKE cycle with mem_clk_en=1, then mem_rd_en, and correct data is returned.
REQ-027 Assert rst_n=0 during the second WRITE cycle with 2 queued requests -> all outputs at reset values immediately, queue empty, no response after release.
